// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin 8N1 UART transmit sequencer paced by txclk_en.
// Optional even-parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_scheduler #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              txclk_en,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic              tx,
    output logic              busy,
    output logic [2:0]        estado
);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        GRANT  = 3'b001,
        START  = 3'b010,
        DATA   = 3'b011,
        PARITY = 3'b100,
        STOP   = 3'b101
    } state_t;

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic [CW-1:0]     cnt;
    logic              last;
    logic              pick1;
`ifdef UART_TX_PARITY_EN
    logic              par;
`endif

    // req1 wins alone, or on a tie when requester 0 was served last
    always_comb begin
        pick1     = req1 & (~req0 | ~last);
        shift_nxt = shift_q >> 1;
    end

    assign estado = state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            tx      <= 1'b1;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
            last    <= 1'b1;
            shift_q <= '0;
            cnt     <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (req0 | req1) begin
                        state   <= GRANT;
                        busy    <= 1'b1;
                        last    <= pick1;
                        ack0    <= ~pick1;
                        ack1    <= pick1;
                        shift_q <= pick1 ? data1 : data0;
                        cnt     <= '0;
`ifdef UART_TX_PARITY_EN
                        par     <= pick1 ? ^data1 : ^data0;
`endif
                    end
                end
                GRANT: if (txclk_en) begin
                    state <= START;
                    tx    <= 1'b0;
                end
                START: if (txclk_en) begin
                    state <= DATA;
                    tx    <= shift_q[0];
                end
                DATA: if (txclk_en) begin
                    shift_q <= shift_nxt;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= par;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        tx <= shift_nxt[0];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (txclk_en) begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
`endif
                STOP: if (txclk_en) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed + random requests, a UART receiver model
// decodes tx and a round-robin arbitration model predicts the byte order.
module tb_uart_tx_scheduler;
    localparam int DATA_W = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = DATA_W + 3;
    localparam int PAR = 1;
`else
    localparam int NB  = DATA_W + 2;
    localparam int PAR = 0;
`endif

    logic              clock = 1'b0;
    logic              resetn = 1'b1;
    logic              txclk_en = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [DATA_W-1:0] data0 = '0, data1 = '0;
    logic              ack0, ack1, tx, busy;
    logic [2:0]        estado;

    uart_tx_scheduler #(.DATA_W(DATA_W)) dut (
        .clock(clock), .resetn(resetn), .txclk_en(txclk_en),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .tx(tx), .busy(busy), .estado(estado)
    );

    always #5 clock = ~clock;

    int tcnt = 0;
    always @(negedge clock) begin
        tcnt     = (tcnt + 1) % 4;
        txclk_en = (tcnt == 0);
    end

    int vectors = 0, errs = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] rx_q[$];
    int ack_tot0 = 0, ack_tot1 = 0, est4 = 0;
    bit last_m = 1'b1;

    always @(negedge clock) begin
        if (ack0 === 1'b1) ack_tot0++;
        if (ack1 === 1'b1) ack_tot1++;
        if (estado === 3'd4) est4++;
    end

    // receiver model: sample mid-bit, demand each bit hold for a full 4-clock interval
    bit rx_busy = 1'b0;
    int rx_cnt = 0;
    logic cur;
    logic [NB-1:0] bits;
    logic [DATA_W-1:0] rx_byte;
    always @(negedge clock) begin
        if (!resetn) rx_busy = 1'b0;
        else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                cur     = 1'b0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % 4 == 0) cur = tx;
            else chk("bit_width", tx, cur);
            if (rx_cnt % 4 == 2) begin
                bits[rx_cnt/4] = tx;
                if (rx_cnt / 4 == NB - 1) begin
                    rx_byte = bits[DATA_W:1];
                    chk("start_bit", bits[0], 1'b0);
                    chk("stop_bit", bits[NB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", bits[DATA_W+1], ^rx_byte);
`endif
                    rx_q.push_back(rx_byte);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    task automatic wait_ack(output int who);
        who = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (ack0 === 1'b1) begin who = 0; break; end
            if (ack1 === 1'b1) begin who = 1; break; end
        end
    endtask

    task automatic drain_and_compare();
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (!busy && !rx_busy) break;
        end
        chk("drain_busy", busy, 1'b0);
        chk("frame_count", rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0)
            chk("rx_byte", rx_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic send0(input logic [DATA_W-1:0] d);
        int w;
        data0 = d; req0 = 1'b1;
        wait_ack(w);
        chk("send_ack", w, 0);
        req0 = 1'b0;
        exp_q.push_back(d);
        last_m = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        last_m = 1'b1;
    endtask

    initial begin
        int w, who, a0, a1, e4, found, early, seen;
        bit p0, p1;
        logic [DATA_W-1:0] d;

        #1 resetn = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_estado", estado, 3'd0);
        chk("rst_ack0", ack0, 1'b0);
        chk("rst_ack1", ack1, 1'b0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // tie straight out of reset: req0 first, then alternate
        data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = last_m ? 0 : 1;
            wait_ack(who);
            chk("tie_order", who, w);
            exp_q.push_back(w == 1 ? data1 : data0);
            last_m = w[0];
        end
        req0 = 1'b0; req1 = 1'b0;
        drain_and_compare();

        // single request 8'hA5, ack one clock after req
        a0 = ack_tot0;
        @(negedge clock);
        data0 = 8'hA5; req0 = 1'b1;
        @(negedge clock);
        chk("ack0_latency", ack0, 1'b1);
        chk("grant_state", estado, 3'd1);
        req0 = 1'b0;
        exp_q.push_back(8'hA5);
        last_m = 1'b0;
        drain_and_compare();
        chk("ack0_once", ack_tot0 - a0, 1);
        chk("idle_after", estado, 3'd0);

        // parity state occupancy
        e4 = est4;
        send0(8'h07);
        drain_and_compare();
        chk("parity_cycles", est4 - e4, PAR * 4);

        // late request waits for the first IDLE cycle
        send0(8'($urandom));
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (estado === 3'd3) begin found = 1; break; end
        end
        chk("late_reach_data", found, 1);
        data1 = 8'($urandom); req1 = 1'b1;
        early = 0; seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (estado === 3'd0) begin seen = 1; break; end
            if (ack1 === 1'b1) early = 1;
        end
        chk("late_no_early_ack1", early, 0);
        chk("late_idle_seen", seen, 1);
        chk("late_idle_ack1", ack1, 1'b0);
        @(negedge clock);
        chk("late_ack1", ack1, 1'b1);
        chk("late_grant", estado, 3'd1);
        req1 = 1'b0;
        exp_q.push_back(data1);
        last_m = 1'b1;
        drain_and_compare();

        // withdrawn one-clock req1 pulse mid-frame
        a1 = ack_tot1;
        send0(8'($urandom));
        repeat (10) @(negedge clock);
        data1 = 8'($urandom); req1 = 1'b1;
        @(negedge clock);
        req1 = 1'b0;
        drain_and_compare();
        chk("withdrawn_no_ack1", ack_tot1 - a1, 0);

        // async reset during data bit 3, req0 held through it
        d = 8'($urandom);
        data0 = d; req0 = 1'b1;
        wait_ack(who);
        chk("rstmid_ack", who, 0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (estado === 3'd3) begin found = 1; break; end
        end
        chk("rstmid_reach_data", found, 1);
        repeat (13) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("rstmid_tx", tx, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_estado", estado, 3'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        last_m = 1'b1;
        wait_ack(who);
        chk("rstmid_regrant", who, 0);
        req0 = 1'b0;
        exp_q.push_back(d);
        last_m = 1'b0;
        drain_and_compare();

        // random request patterns against the round-robin model
        for (int r = 0; r < 12; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            p0 = (mode != 1); p1 = (mode != 0);
            data0 = 8'($urandom); data1 = 8'($urandom);
            req0 = p0; req1 = p1;
            while (p0 || p1) begin
                w = (p0 && p1) ? (last_m ? 0 : 1) : (p1 ? 1 : 0);
                wait_ack(who);
                chk("rnd_arb", who, w);
                if (who < 0) begin
                    req0 = 1'b0; req1 = 1'b0;
                    break;
                end
                exp_q.push_back(w == 1 ? data1 : data0);
                last_m = w[0];
                if (who == 0) begin req0 = 1'b0; p0 = 1'b0; end
                else          begin req1 = 1'b0; p1 = 1'b0; end
            end
            drain_and_compare();
            repeat ($urandom_range(0, 5)) @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one 8N1 UART transmit line between two byte-producing requesters. Arbitrates round-robin, latches the winner's byte, and serializes it on `tx`, paced by the `txclk_en` tick from `baud_rate_gen`. Sits beside `arbitrator` as the transmit-side sequencer. Exports its FSM state on `estado` for bench monitoring.

## Interface
Parameters:
- `DATA_W`, default 8: payload bits per frame, sent LSB first.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `txclk_en`  in  1  one-cycle baud tick; one bit period spans from tick to tick.
- `req0`  in  1  requester 0 has a byte.
- `data0`  in  DATA_W  requester 0 byte; must be stable while `req0` is high.
- `ack0`  out  1  one-cycle pulse: `data0` captured.
- `req1`  in  1  requester 1 has a byte.
- `data1`  in  DATA_W  requester 1 byte.
- `ack1`  out  1  one-cycle pulse: `data1` captured.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high whenever state ≠ IDLE.
- `estado`  out  3  current FSM state encoding.

## Operation
FSM states and `estado` encodings:
- IDLE = 000
- GRANT = 001
- START = 010
- DATA = 011
- PARITY = 100
- STOP = 101

Transitions:
- **IDLE:** `tx`=1. If any `req` is high at a clock edge, pick the winner, capture its data into the shift register, set bit count to 0, and go to GRANT. A `txclk_en` tick in IDLE is ignored.
- **GRANT:** `tx`=1. The winner's `ack` is high for exactly the first GRANT cycle. Wait here for `txclk_en`, then go to START.
- **START:** `tx`=0. On `txclk_en`, go to DATA.
- **DATA:** `tx`=shift[0]. On each `txclk_en`, shift right and increment the count. On the tick that ends bit DATA_W−1, go to PARITY (macro defined) or STOP.
- **PARITY:** `tx`=XOR of the captured byte (even parity). On `txclk_en`, go to STOP.
- **STOP:** `tx`=1. On `txclk_en`, go to IDLE.

Arbitration:
- Round-robin with a 1-bit `last` pointer.
- When both requests are high, the requester ≠ `last` wins. A lone requester always wins.
- `last` updates to the winner at grant.
- Reset value of `last` is 1, so `req0` wins the first tie.

Requester protocol:
- Hold `req` high and keep data stable until `ack`.
- If `req` is still high after the `ack` cycle, it is a new byte.
- Dropping `req` before grant withdraws the request with no side effects.

Other rules:
- Inputs are not sampled outside IDLE; a request arriving mid-frame waits.
- All outputs are registered.
- `tx` changes only on the cycle after a tick or a grant.

## Timing
- Reset (async assert, any state): `tx`=1, `ack0`=`ack1`=0, `busy`=0, `estado`=000, `last`=1, shift register and count = 0.
- Reset mid-frame aborts the frame immediately with `tx` high. No retransmission.
- Grant latency: 1 clock from `req` seen in IDLE to GRANT / `ack`.
- Every bit (start, data, parity, stop) lasts exactly one tick interval. The first tick after GRANT begins the start bit.
- Frame length: DATA_W+2 tick intervals, or DATA_W+3 with parity. This is plus a GRANT wait of at most one tick interval.
- Back-to-back: the STOP tick moves the FSM to IDLE. A pending request is granted on the next edge, so there is exactly one IDLE cycle between frames.
- A `txclk_en` tick in the same cycle as a grant is not counted. GRANT waits for the next tick.

## Configuration
- `UART_TX_PARITY_EN`:
  - **Defined:** the PARITY state is inserted after the last data bit and carries even parity, so the frame is 11 bits for DATA_W=8.
  - **Undefined:** the PARITY state and its logic are absent, DATA goes straight to STOP, and encoding 100 never appears.

## Test plan
All cases use `txclk_en` every 4 clocks.
- **Single request, no parity:** `req0`=1, `data0`=8'hA5.
  - `ack0` pulses once, 1 clock after `req0`.
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks wide.
  - `estado` returns to 000 after STOP.
- **Tie:** `req0`=`req1`=1, `data0`=8'h11, `data1`=8'h22, both held.
  - Frames go out in the order 11, 22, 11, 22.
  - `ack`s alternate, starting with `ack0`.
- **Parity build** (macro defined): `data0`=8'h07.
  - Parity bit = 1; frame is 11 bits.
  - `estado` visits 100 for one tick interval.
- **Late request:** `req1` rises while a `req0` frame is in DATA.
  - `ack1` stays 0 until the first IDLE cycle.
  - Then `ack1` pulses and the next frame starts with no extra IDLE cycles.
- **Reset mid-frame:** drop `resetn` during DATA bit 3.
  - `tx`=1, `busy`=0, `estado`=000 immediately, without waiting for a clock edge.
  - After release with `req0` held, a new full frame is sent.
- **Withdrawn request:** pulse `req1` for 1 clock while a frame is in progress.
  - No `ack1`, no extra frame.
